// File: rtl/keypad_pkg.sv
// Shared constants, state encoding and key decode for the keypad entry buffer.
package keypad_pkg;

  localparam int KEY_STAR = 9;
  localparam int KEY_ZERO = 10;
  localparam int KEY_HASH = 11;

  // Segment order {a,b,c,d,e,f,g}, a is the MSB, active-high.
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110010;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic {ST_EDIT = 1'b0, ST_HOLD = 1'b1} entry_state_e;

  // Bits 0..8 are keys 1..9; the zero key (and anything else) decodes to 0.
  function automatic logic [3:0] scan_to_bcd(input logic [11:0] scan);
    scan_to_bcd = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (scan[i]) scan_to_bcd = 4'(i + 1);
    end
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// BCD digit to 7-segment pattern, with blanking and optional output inversion.
module seg7_encode
  import keypad_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  logic [6:0] pattern;

  always_comb begin
    pattern = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    pattern = SEG_0;
        4'd1:    pattern = SEG_1;
        4'd2:    pattern = SEG_2;
        4'd3:    pattern = SEG_3;
        4'd4:    pattern = SEG_4;
        4'd5:    pattern = SEG_5;
        4'd6:    pattern = SEG_6;
        4'd7:    pattern = SEG_7;
        4'd8:    pattern = SEG_8;
        4'd9:    pattern = SEG_9;
        default: pattern = SEG_BLANK;
      endcase
    end
  end

  assign seg = SEG_ACTIVE_LOW ? ~pattern : pattern;

endmodule

// File: rtl/keypad_entry_display.sv
// Multi-digit keypad entry buffer: edits BCD digits under a cursor, drives one
// 7-segment pattern per position, and pulses en on commit (*) / err on bad input.
module keypad_entry_display
  import keypad_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter bit WRAP           = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [11:0]                   scan_data,
  input  logic                          valid,
  output logic [7*NUM_DIGITS-1:0]       seg,
  output logic [4*NUM_DIGITS-1:0]       digits,
  output logic [$clog2(NUM_DIGITS)-1:0] cursor,
  output logic                          en,
  output logic                          err
);

  localparam int CW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] LAST_POS = CW'(NUM_DIGITS - 1);

  entry_state_e            state_q, state_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   filled_q, filled_d;
  logic [CW-1:0]           cursor_q, cursor_d, cursor_nx;
  logic                    en_d, err_d, valid_q;
  logic                    accept, legal, is_star, is_hash, at_last;
  logic [3:0]              key_bcd;

  // valid has no ready: a key is taken once, on the cycle valid rises; a level
  // held for many cycles (or held through reset, since valid_q resets high) is
  // not taken again until valid drops and rises.
  assign accept    = valid && !valid_q;
  assign legal     = $onehot(scan_data);
  assign is_star   = scan_data[KEY_STAR];
  assign is_hash   = scan_data[KEY_HASH];
  assign key_bcd   = scan_to_bcd(scan_data);
  assign at_last   = (cursor_q == LAST_POS);
  assign cursor_nx = cursor_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    filled_d = filled_q;
    cursor_d = cursor_q;
    en_d     = 1'b0;
    err_d    = 1'b0;
    if (accept) begin
      if (!legal) begin
        err_d = 1'b1;
      end else if (is_star) begin
        en_d    = 1'b1;
        state_d = ST_HOLD;
      end else if (is_hash) begin
        if (state_q == ST_EDIT) begin
          if (!at_last) begin
            cursor_d                   = cursor_nx;
            digits_d[4*cursor_nx +: 4] = 4'd0;
            filled_d[cursor_nx]        = 1'b1;
          end else if (WRAP) begin
            cursor_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end else if (state_q == ST_HOLD) begin
        // A digit after commit starts a fresh entry.
        digits_d      = '0;
        filled_d      = '0;
        digits_d[3:0] = key_bcd;
        filled_d[0]   = 1'b1;
        cursor_d      = '0;
        state_d       = ST_EDIT;
      end else begin
        digits_d[4*cursor_q +: 4] = key_bcd;
        filled_d[cursor_q]        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EDIT;
      digits_q <= '0;
      filled_q <= NUM_DIGITS'(1);
      cursor_q <= '0;
      en       <= 1'b0;
      err      <= 1'b0;
      valid_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      filled_q <= filled_d;
      cursor_q <= cursor_d;
      en       <= en_d;
      err      <= err_d;
      valid_q  <= valid;
    end
  end

  assign digits = digits_q;
  assign cursor = cursor_q;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_seg
    seg7_encode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg (
      .bcd  (digits_q[4*i +: 4]),
      .blank(!filled_q[i]),
      .seg  (seg[7*i +: 7])
    );
  end

endmodule

// File: tb/tb_keypad_entry_display.sv
// Bench for keypad_entry_display: a saturating (WRAP=0) and a wrapping (WRAP=1)
// instance share stimulus and are compared against a key-level reference model.
module tb_keypad_entry_display;

  localparam int N = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    valid;
  logic [11:0]             scan_data;
  logic [1:0][7*N-1:0]     seg_o;
  logic [1:0][4*N-1:0]     digits_o;
  logic [1:0][1:0]         cursor_o;
  logic [1:0]              en_o;
  logic [1:0]              err_o;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state, one set per instance (index = WRAP value).
  int m_dig[2][N];
  bit m_fil[2][N];
  int m_cur[2];
  bit m_hold[2];
  bit m_en[2];
  bit m_err[2];
  bit m_vq[2];

  always #5 clk = ~clk;

  keypad_entry_display #(.NUM_DIGITS(N), .WRAP(1'b0), .SEG_ACTIVE_LOW(1'b0)) dut_sat (
    .clk(clk), .rst(rst), .scan_data(scan_data), .valid(valid),
    .seg(seg_o[0]), .digits(digits_o[0]), .cursor(cursor_o[0]),
    .en(en_o[0]), .err(err_o[0])
  );

  keypad_entry_display #(.NUM_DIGITS(N), .WRAP(1'b1), .SEG_ACTIVE_LOW(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .scan_data(scan_data), .valid(valid),
    .seg(seg_o[1]), .digits(digits_o[1]), .cursor(cursor_o[1]),
    .en(en_o[1]), .err(err_o[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110010;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic model_reset(input int u);
    for (int i = 0; i < N; i++) begin
      m_dig[u][i] = 0;
      m_fil[u][i] = (i == 0);
    end
    m_cur[u]  = 0;
    m_hold[u] = 1'b0;
    m_en[u]   = 1'b0;
    m_err[u]  = 1'b0;
    m_vq[u]   = 1'b1;
  endtask

  // One clock edge of the entry rules, applied to the inputs present at the edge.
  task automatic model_update(input int u);
    int k;
    int d;
    if (rst) begin
      model_reset(u);
      return;
    end
    m_en[u]  = 1'b0;
    m_err[u] = 1'b0;
    if (valid && !m_vq[u]) begin
      k = -1;
      for (int b = 0; b < 12; b++) if (scan_data[b]) k = b;
      if ($countones(scan_data) != 1) begin
        m_err[u] = 1'b1;
      end else if (k == 9) begin
        m_en[u]   = 1'b1;
        m_hold[u] = 1'b1;
      end else if (k == 11) begin
        if (!m_hold[u]) begin
          if (m_cur[u] < N - 1) begin
            m_cur[u]++;
            m_dig[u][m_cur[u]] = 0;
            m_fil[u][m_cur[u]] = 1'b1;
          end else if (u == 1) begin
            m_cur[u] = 0;
          end else begin
            m_err[u] = 1'b1;
          end
        end
      end else begin
        d = (k == 10) ? 0 : k + 1;
        if (m_hold[u]) begin
          for (int i = 0; i < N; i++) begin
            m_dig[u][i] = 0;
            m_fil[u][i] = 1'b0;
          end
          m_dig[u][0] = d;
          m_fil[u][0] = 1'b1;
          m_cur[u]    = 0;
          m_hold[u]   = 1'b0;
        end else begin
          m_dig[u][m_cur[u]] = d;
          m_fil[u][m_cur[u]] = 1'b1;
        end
      end
    end
    m_vq[u] = valid;
  endtask

  task automatic check_all();
    logic [4*N-1:0] exp_dig;
    logic [7*N-1:0] exp_seg;
    for (int u = 0; u < 2; u++) begin
      exp_dig = '0;
      exp_seg = '0;
      for (int i = 0; i < N; i++) begin
        exp_dig[4*i +: 4] = 4'(m_dig[u][i]);
        if (m_fil[u][i]) exp_seg[7*i +: 7] = seg_ref(m_dig[u][i]);
      end
      check($sformatf("u%0d_digits", u), 64'(digits_o[u]), 64'(exp_dig));
      check($sformatf("u%0d_seg", u), 64'(seg_o[u]), 64'(exp_seg));
      check($sformatf("u%0d_cursor", u), 64'(cursor_o[u]), 64'(m_cur[u]));
      check($sformatf("u%0d_en", u), 64'(en_o[u]), 64'(m_en[u]));
      check($sformatf("u%0d_err", u), 64'(err_o[u]), 64'(m_err[u]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
    check_all();
  endtask

  task automatic press(input int k);
    scan_data = 12'(1) << k;
    valid     = 1'b1;
    step();
    valid     = 1'b0;
    step();
  endtask

  initial begin
    int r;
    rst       = 1'b1;
    valid     = 1'b0;
    scan_data = '0;
    model_reset(0);
    model_reset(1);
    step();
    step();
    rst = 1'b0;
    step();
    step();
    check("reset_seg", 64'(seg_o[0]), 64'h7E);
    check("reset_cursor", 64'(cursor_o[0]), 64'd0);

    // 1 # 2 # 3 * : entry 1,2,3 then commit.
    press(0);
    press(11);
    press(1);
    press(11);
    press(2);
    scan_data = 12'(1) << 9;
    valid     = 1'b1;
    step();
    check("commit_en", 64'(en_o[0]), 64'd1);
    valid = 1'b0;
    step();
    check("commit_en_drop", 64'(en_o[0]), 64'd0);
    check("entry_digits", 64'(digits_o[0]), 64'h0321);
    check("entry_seg", 64'(seg_o[0][20:0]), 64'({7'b1111001, 7'b1101101, 7'b0110000}));
    check("entry_blank3", 64'(seg_o[0][27:21]), 64'd0);

    // Key 5 held for 10 cycles, then a two-bit code.
    scan_data = 12'(1) << 4;
    valid     = 1'b1;
    for (int i = 0; i < 10; i++) step();
    valid = 1'b0;
    step();
    check("held_digits", 64'(digits_o[0]), 64'h0005);
    scan_data = 12'h003;
    valid     = 1'b1;
    step();
    check("multi_err", 64'(err_o[0]), 64'd1);
    valid = 1'b0;
    step();

    // Cursor to the last position, then # once more.
    press(11);
    press(11);
    press(11);
    check("cursor_last", 64'(cursor_o[0]), 64'd3);
    scan_data = 12'(1) << 11;
    valid     = 1'b1;
    step();
    check("sat_err", 64'(err_o[0]), 64'd1);
    check("sat_cursor", 64'(cursor_o[0]), 64'd3);
    check("wrap_err", 64'(err_o[1]), 64'd0);
    check("wrap_cursor", 64'(cursor_o[1]), 64'd0);
    valid = 1'b0;
    step();

    // Commit, then key 7 in HOLD starts a new entry; * in HOLD re-pulses en.
    press(9);
    press(6);
    check("hold7_digits", 64'(digits_o[0]), 64'h0007);
    check("hold7_seg", 64'(seg_o[0]), 64'h72);
    press(9);
    scan_data = 12'(1) << 9;
    valid     = 1'b1;
    step();
    check("hold_repulse", 64'(en_o[0]), 64'd1);
    valid = 1'b0;
    step();

    // Reset on the same edge as an accepted *, valid held through release.
    valid = 1'b1;
    step();
    valid = 1'b0;
    step();
    valid = 1'b1;
    rst   = 1'b1;
    step();
    check("rst_en", 64'(en_o[0]), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("rst_hold_en", 64'(en_o[0]), 64'd0);
    valid = 1'b0;
    step();
    valid = 1'b1;
    step();
    check("rst_reedge_en", 64'(en_o[0]), 64'd1);
    valid = 1'b0;
    step();

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      scan_data = 12'(1) << $urandom_range(0, 11);
      else if (r < 80) scan_data = '0;
      else             scan_data = 12'($urandom);
      valid = ($urandom_range(0, 1) == 1);
      rst   = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
